// File: rtl/intm_fu_pkg.sv
// ============================================================================
// Module : intm_fu_pkg
// Brief  : Shared types for the integer multiply/divide functional unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package intm_fu_pkg;

  localparam int XLEN     = 32;
  localparam int ROB_ID_W = 6;
  localparam int ARCH_W   = 5;
  localparam int PHY_W    = 7;

  // RV32M funct3 ordering
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } mdopc_t;

  typedef logic [1:0] intm_fu_state_t;
  localparam intm_fu_state_t ST_IDLE = 2'd0;
  localparam intm_fu_state_t ST_BUSY = 2'd1;
  localparam intm_fu_state_t ST_DONE = 2'd2;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [ARCH_W-1:0]   rd_arch;
    logic [PHY_W-1:0]    rd_phy;
    mdopc_t              fu_opcode;
    logic [XLEN-1:0]     rs1_value;
    logic [XLEN-1:0]     rs2_value;
  } intm_rs_reg_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [ARCH_W-1:0]   rd_arch;
    logic [PHY_W-1:0]    rd_phy;
    logic [XLEN-1:0]     rd_value;
    logic [XLEN-1:0]     rs1_value_dbg;
    logic [XLEN-1:0]     rs2_value_dbg;
  } fu_cdb_reg_t;

  // Divide-by-zero and signed overflow complete without iterating.
  function automatic logic md_is_special(input mdopc_t op, input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
    logic ovf;
    ovf = (op inside {MD_DIV, MD_REM}) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) && ((b == '0) || ovf);
  endfunction

  function automatic logic [XLEN-1:0] md_special_result(input mdopc_t op,
                                                        input logic [XLEN-1:0] a,
                                                        input logic [XLEN-1:0] b);
    if (b == '0) return (op inside {MD_DIV, MD_DIVU}) ? 32'hFFFF_FFFF : a;
    return (op == MD_DIV) ? 32'h8000_0000 : 32'h0000_0000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/intm_muldiv_core.sv
// ============================================================================
// Module : intm_muldiv_core
// Brief  : Iterative shift-add multiplier / restoring divider on magnitudes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intm_muldiv_core
  import intm_fu_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  mdopc_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN-1:0]   hi_n, lo_n, a_mag, b_mag;
  mdopc_t            op_q, op_d;
  logic              neg_q, neg_d, a_sgn, b_sgn;
  logic [XLEN:0]     sum, shifted;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    a_sgn = (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && a[XLEN-1];
    b_sgn = (op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM}) && b[XLEN-1];
    a_mag = a_sgn ? -a : a;
    b_mag = b_sgn ? -b : b;
  end

  // hi holds the upper product / partial remainder, lo the multiplier / quotient
  always_comb begin
    hi_n    = hi_q;
    lo_n    = lo_q;
    sum     = '0;
    shifted = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) begin
        shifted = {hi_n, lo_n[XLEN-1]};
        if (shifted >= {1'b0, b_q}) begin
          hi_n = shifted[XLEN-1:0] - b_q;
          lo_n = {lo_n[XLEN-2:0], 1'b1};
        end else begin
          hi_n = shifted[XLEN-1:0];
          lo_n = {lo_n[XLEN-2:0], 1'b0};
        end
      end else begin
        sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        hi_n = sum[XLEN:1];
        lo_n = {sum[0], lo_n[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    op_d  = op_q;
    neg_d = neg_q;
    if (start) begin
      hi_d  = '0;
      lo_d  = a_mag;
      b_d   = b_mag;
      op_d  = op;
      neg_d = (op == MD_REM) ? a_sgn : (a_sgn ^ b_sgn);
    end else if (step) begin
      hi_d = hi_n;
      lo_d = lo_n;
    end
  end

  // Result reflects the state after the current step's iterations.
  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_q) prod = -prod;
    case (op_q)
      MD_MUL:                       result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = neg_q ? -lo_n : lo_n;
      default:                      result = neg_q ? -hi_n : hi_n;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      op_q  <= MD_MUL;
      neg_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      op_q  <= op_d;
      neg_q <= neg_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/intm_fu.sv
// ============================================================================
// Module : intm_fu
// Brief  : RV32M multiply/divide FU: issue/CDB handshakes, FSM, tag holding.
//          Define INTM_FU_DBG_EN to return issued operands in the CDB packet.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intm_fu
  import intm_fu_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         issue_valid,
  output logic         issue_ready,
  input  intm_rs_reg_t issue_pkt,
  output logic         cdb_valid,
  input  logic         cdb_ready,
  output fu_cdb_reg_t  cdb_pkt
);

  localparam logic [5:0] CNT_INIT = 6'(XLEN / STEPS_PER_CYCLE);

  intm_fu_state_t      state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [ROB_ID_W-1:0] rob_id_q, rob_id_d;
  logic [ARCH_W-1:0]   rd_arch_q, rd_arch_d;
  logic [PHY_W-1:0]    rd_phy_q, rd_phy_d;
  logic [XLEN-1:0]     rd_value_q, rd_value_d;
  logic [XLEN-1:0]     core_result;
  logic                special, issue_fire;

  assign issue_ready = (state_q == ST_IDLE) && !flush;
  assign cdb_valid   = (state_q == ST_DONE);
  assign issue_fire  = issue_valid && issue_ready;
  assign special     = md_is_special(issue_pkt.fu_opcode, issue_pkt.rs1_value,
                                     issue_pkt.rs2_value);

  intm_muldiv_core #(
    .STEPS_PER_CYCLE(STEPS_PER_CYCLE)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (issue_fire),
    .step  ((state_q == ST_BUSY) && !flush),
    .op    (issue_pkt.fu_opcode),
    .a     (issue_pkt.rs1_value),
    .b     (issue_pkt.rs2_value),
    .result(core_result)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rob_id_d   = rob_id_q;
    rd_arch_d  = rd_arch_q;
    rd_phy_d   = rd_phy_q;
    rd_value_d = rd_value_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_valid) begin
            rob_id_d  = issue_pkt.rob_id;
            rd_arch_d = issue_pkt.rd_arch;
            rd_phy_d  = issue_pkt.rd_phy;
            if (special) begin
              rd_value_d = md_special_result(issue_pkt.fu_opcode, issue_pkt.rs1_value,
                                             issue_pkt.rs2_value);
              state_d    = ST_DONE;
            end else begin
              state_d = ST_BUSY;
              cnt_d   = CNT_INIT;
            end
          end
        end
        ST_BUSY: begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            rd_value_d = core_result;
            state_d    = ST_DONE;
          end
        end
        ST_DONE: if (cdb_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rob_id_q   <= '0;
      rd_arch_q  <= '0;
      rd_phy_q   <= '0;
      rd_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rob_id_q   <= rob_id_d;
      rd_arch_q  <= rd_arch_d;
      rd_phy_q   <= rd_phy_d;
      rd_value_q <= rd_value_d;
    end
  end

`ifdef INTM_FU_DBG_EN
  logic [XLEN-1:0] rs1_dbg_q, rs1_dbg_d, rs2_dbg_q, rs2_dbg_d;

  always_comb begin
    rs1_dbg_d = issue_fire ? issue_pkt.rs1_value : rs1_dbg_q;
    rs2_dbg_d = issue_fire ? issue_pkt.rs2_value : rs2_dbg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_dbg_q <= '0;
      rs2_dbg_q <= '0;
    end else begin
      rs1_dbg_q <= rs1_dbg_d;
      rs2_dbg_q <= rs2_dbg_d;
    end
  end
`endif

  always_comb begin
    cdb_pkt          = '0;
    cdb_pkt.rob_id   = rob_id_q;
    cdb_pkt.rd_arch  = rd_arch_q;
    cdb_pkt.rd_phy   = rd_phy_q;
    cdb_pkt.rd_value = rd_value_q;
`ifdef INTM_FU_DBG_EN
    cdb_pkt.rs1_value_dbg = rs1_dbg_q;
    cdb_pkt.rs2_value_dbg = rs2_dbg_q;
`else
    cdb_pkt.rs1_value_dbg = '0;
    cdb_pkt.rs2_value_dbg = '0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_intm_fu.sv
// ============================================================================
// Module : tb_intm_fu
// Brief  : Self-checking bench for intm_fu at STEPS_PER_CYCLE 1 and 4.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intm_fu;
  import intm_fu_pkg::*;

  localparam int STEPS0 = 1;
  localparam int STEPS1 = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   flush, issue_valid, issue_ready, cdb_valid, cdb_ready;
  intm_rs_reg_t issue_pkt [2];
  fu_cdb_reg_t  cdb_pkt [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  intm_fu #(.STEPS_PER_CYCLE(STEPS0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .issue_valid(issue_valid[0]), .issue_ready(issue_ready[0]), .issue_pkt(issue_pkt[0]),
    .cdb_valid(cdb_valid[0]), .cdb_ready(cdb_ready[0]), .cdb_pkt(cdb_pkt[0])
  );

  intm_fu #(.STEPS_PER_CYCLE(STEPS1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .issue_valid(issue_valid[1]), .issue_ready(issue_ready[1]), .issue_pkt(issue_pkt[1]),
    .cdb_valid(cdb_valid[1]), .cdb_ready(cdb_ready[1]), .cdb_pkt(cdb_pkt[1])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural reference using 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input mdopc_t op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (op)
      MD_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      MD_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MD_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      MD_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_special(input mdopc_t op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit is_div, ovf;
    is_div = (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    ovf = ((op == MD_DIV) || (op == MD_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    return is_div && (b == 0 || ovf);
  endfunction

  function automatic int steps_of(input int sel);
    return (sel == 0) ? STEPS0 : STEPS1;
  endfunction

  task automatic drive_pkt(input int sel, input mdopc_t op, input logic [31:0] a,
                           input logic [31:0] b, input logic [5:0] rob);
    issue_pkt[sel].rob_id    = rob;
    issue_pkt[sel].rd_arch   = rob[4:0];
    issue_pkt[sel].rd_phy    = {1'b1, rob};
    issue_pkt[sel].fu_opcode = op;
    issue_pkt[sel].rs1_value = a;
    issue_pkt[sel].rs2_value = b;
  endtask

  // Presents an op at a negedge; returns #1 after the handshake edge.
  task automatic issue_op(input int sel, input mdopc_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] rob);
    @(negedge clk);
    drive_pkt(sel, op, a, b, rob);
    issue_valid[sel] = 1'b1;
    #1;
    check("issue_ready before handshake", issue_ready[sel], 1'b1);
    @(posedge clk);
    #1;
    issue_valid[sel] = 1'b0;
  endtask

  // Latency = cycles from the handshake edge until cdb_valid is first seen.
  task automatic wait_valid(input int sel, output int lat);
    lat = 1;
    while (!cdb_valid[sel] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input int sel, input mdopc_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string tag);
    int         lat, exp_lat;
    logic [5:0] rob;
    rob     = 6'($urandom);
    exp_lat = ref_special(op, a, b) ? 1 : (32 / steps_of(sel)) + 1;
    issue_op(sel, op, a, b, rob);
    wait_valid(sel, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rd_value"}, cdb_pkt[sel].rd_value, exp);
    check({tag, " rob_id"}, cdb_pkt[sel].rob_id, rob);
    check({tag, " rd_arch"}, cdb_pkt[sel].rd_arch, rob[4:0]);
    check({tag, " rd_phy"}, cdb_pkt[sel].rd_phy, {1'b1, rob});
`ifdef INTM_FU_DBG_EN
    check({tag, " rs1_dbg"}, cdb_pkt[sel].rs1_value_dbg, a);
    check({tag, " rs2_dbg"}, cdb_pkt[sel].rs2_value_dbg, b);
`else
    check({tag, " rs1_dbg"}, cdb_pkt[sel].rs1_value_dbg, 32'h0);
    check({tag, " rs2_dbg"}, cdb_pkt[sel].rs2_value_dbg, 32'h0);
`endif
    if (cdb_ready[sel]) begin
      @(posedge clk);
      #1;
      check({tag, " valid drop"}, cdb_valid[sel], 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, seen, sel;
    mdopc_t     op;
    logic [31:0] a, b;
    flush       = '0;
    issue_valid = '0;
    cdb_ready   = 2'b11;
    drive_pkt(0, MD_MUL, 0, 0, 0);
    drive_pkt(1, MD_MUL, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset cdb_valid", cdb_valid, 2'b00);
    check("reset cdb_pkt0", cdb_pkt[0], '0);
    check("reset cdb_pkt1", cdb_pkt[1], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("issue_ready after reset", issue_ready, 2'b11);

    run_op(0, MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3");
    run_op(0, MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU");
    run_op(0, MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "MULH");
    run_op(0, MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
    run_op(0, MD_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "DIV -7/2");
    run_op(0, MD_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "REM -7/2");
    run_op(0, MD_DIVU,   32'd100,      32'd0,        32'hFFFF_FFFF, "DIVU /0");
    run_op(0, MD_REMU,   32'd100,      32'd0,        32'd100,       "REMU /0");
    run_op(0, MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
    run_op(0, MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "REM ovf");

    // Backpressure in DONE
    cdb_ready[0] = 1'b0;
    issue_op(0, MD_DIVU, 32'd1000, 32'd7, 6'd21);
    wait_valid(0, lat);
    check("bp latency", lat, 33);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp cdb_valid held", cdb_valid[0], 1'b1);
      check("bp rd_value held", cdb_pkt[0].rd_value, 32'h0000_008E);
      check("bp rob_id held", cdb_pkt[0].rob_id, 6'd21);
      check("bp issue_ready low", issue_ready[0], 1'b0);
    end
    @(negedge clk);
    cdb_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp release valid", cdb_valid[0], 1'b0);
    check("bp release ready", issue_ready[0], 1'b1);
    run_op(0, MD_MUL, 32'd12345, 32'd678, 32'd8369910, "after bp");

    // Flush on the 10th cycle of BUSY
    issue_op(0, MD_MUL, 32'd3, 32'd5, 6'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b1;
    #1;
    check("flush gates issue_ready", issue_ready[0], 1'b0);
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    #1;
    check("flush busy valid", cdb_valid[0], 1'b0);
    check("flush busy ready", issue_ready[0], 1'b1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (cdb_valid[0]) seen++;
    end
    check("flush busy no result", seen, 0);

    // Issue in the flush cycle is refused
    @(negedge clk);
    drive_pkt(0, MD_DIVU, 32'd5, 32'd0, 6'd3);
    flush[0] = 1'b1;
    issue_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    issue_valid[0] = 1'b0;
    #1;
    check("flush issue refused ready", issue_ready[0], 1'b1);
    check("flush issue refused valid", cdb_valid[0], 1'b0);

    // Flush in DONE together with cdb_ready
    cdb_ready[0] = 1'b0;
    issue_op(0, MD_DIVU, 32'd9, 32'd0, 6'd4);
    wait_valid(0, lat);
    check("flush done latency", lat, 1);
    @(negedge clk);
    flush[0] = 1'b1;
    cdb_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    #1;
    check("flush done valid", cdb_valid[0], 1'b0);
    check("flush done ready", issue_ready[0], 1'b1);

    run_op(1, MD_DIVU, 32'd1000, 32'd7, 32'h0000_008E, "S4 DIVU");
    run_op(1, MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "S4 MULH");

    for (int i = 0; i < 60; i++) begin
      sel = i % 2;
      op  = mdopc_t'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 300));
        default: ;
      endcase
      run_op(sel, op, a, b, ref_md(op, a, b), $sformatf("rnd%0d op%0d", i, op));
    end

    // Asynchronous reset in the middle of BUSY
    issue_op(1, MD_MUL, 32'd77, 32'd88, 6'd17);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async rst valid", cdb_valid[1], 1'b0);
    check("async rst pkt", cdb_pkt[1], '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (cdb_valid[1]) seen++;
    end
    check("async rst no result", seen, 0);
    run_op(1, MD_REMU, 32'd1000, 32'd7, 32'd6, "post rst REMU");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/intm_fu.md
Name: intm_fu

Overview:
Integer multiply/divide functional unit. Consumes one issued op per transaction from the INTM reservation station (intm_rs_reg_t) and returns the result as fu_cdb_reg_t to the CDB arbiter over a valid/ready handshake. A single shared iterative datapath covers all eight RV32M ops, and a branch flush can cancel work in flight.

Parameters:
STEPS_PER_CYCLE, 1, iteration steps per BUSY cycle; legal values 1, 2, 4; N = 32/STEPS_PER_CYCLE busy cycles per op.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; drops any op in flight
issue_valid  in  1  RS presents an op
issue_ready  out  1  FU can accept an op
issue_pkt  in  intm_rs_reg_t  rob_id, rd_arch, rd_phy, fu_opcode (mdopc_t), rs1_value, rs2_value
cdb_valid  out  1  result valid
cdb_ready  in  1  CDB arbiter grants this FU
cdb_pkt  out  fu_cdb_reg_t  rob_id, rd_arch, rd_phy, rd_value, debug operand values

Behaviour:
- Reset (async, rst_n=0): state IDLE, issue_ready=1 after release, cdb_valid=0, cdb_pkt all zeros, iteration counter 0.
- FSM states: IDLE, BUSY, DONE.
- issue_ready = (state==IDLE) && !flush.
- Issue handshake: issue_valid && issue_ready at a rising edge.
  - Latch rob_id, rd_arch, rd_phy, opcode and operands.
  - Normal case: go to BUSY, counter = N.
  - Special case: go directly to DONE with the result registered.
- BUSY: each edge performs STEPS_PER_CYCLE iterations and decrements the counter. When the counter reaches 1, the final result is registered and the FSM moves to DONE.
- cdb_valid = (state==DONE).
  - Normal op: cdb_valid first high exactly N+1 cycles after the handshake edge.
  - Special op: cdb_valid first high 1 cycle after the handshake edge.
- DONE: cdb_pkt is held stable while cdb_valid && !cdb_ready. When cdb_valid && cdb_ready at an edge, go to IDLE. No new issue is accepted in that same cycle, so minimum spacing between ops is N+2 cycles.
- Multiply (MUL, MULH, MULHSU, MULHU):
  - Operand extension: rs1 is signed for MUL/MULH/MULHSU; rs2 is signed for MUL/MULH.
  - Signed ops run a shift-add on magnitudes; the 64-bit product is negated if the operand signs differ.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide (DIV, DIVU, REM, REMU):
  - Restoring division on magnitudes (unsigned ops use raw values).
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Special cases, no iteration:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM with the same operands returns 0.
- Flush:
  - Synchronous; takes priority over every other event.
  - Next state IDLE and cdb_valid=0 on the next cycle; the result is discarded even if cdb_ready is asserted the same cycle.
  - An issue_valid in the flush cycle is not accepted.
- Opcode encodings outside mdopc_t: unreachable from decode; the result value is don't-care but the FSM timing must still be followed.
- Reset asserted mid-operation: immediate return to the reset values.

Optional Feature:
INTM_FU_DBG_EN
- Defined: cdb_pkt.rs1_value_dbg and cdb_pkt.rs2_value_dbg carry the operands latched at issue, for RVFI.
- Undefined: both fields are driven 0 and the operand latches for these fields are removed.

Decomposition:
- Add intm_fu_state_t (IDLE/BUSY/DONE) to int_rs_types.
- Reuse mdopc_t from uop_types; intm_rs_reg_t and fu_cdb_reg_t are unchanged.
- One sub-module: intm_muldiv_core, the iterative shift-add/restoring datapath with start/step/done signals and an STEPS_PER_CYCLE parameter. intm_fu holds the FSM, handshake and tag registers.

Test Plan:
- MUL, rs1=7, rs2=-3, STEPS=1, cdb_ready=1 -> cdb_valid high 33 cycles after issue; rd_value=0xFFFFFFEB; rob_id and rd_phy echoed.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU(-1, 0xFFFFFFFF) -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF with cdb_valid 1 cycle after issue; DIV 0x80000000/-1 -> 0x80000000.
- Backpressure: hold cdb_ready=0 for 5 cycles in DONE -> cdb_pkt stable and issue_ready=0; release -> IDLE next cycle and the next op is accepted.
- Flush during BUSY (cycle 10), and flush in DONE together with cdb_ready=1 -> no cdb_valid for that op; issue_ready=1 the following cycle.
- STEPS_PER_CYCLE=4 with DIVU 1000/7 -> 0x0000008E, cdb_valid 9 cycles after issue; assert rst_n=0 mid-BUSY -> cdb_valid=0 immediately.
